// File: rtl/mem_arb_pkg.sv
// Shared types for the IM/DM memory port arbiter.
// Holds FSM state, owner encoding and the latched request bundle.
package mem_arb_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;
    localparam int ARB_STRB_W = ARB_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        DONE
    } state_t;

    typedef enum logic {
        OWN_IM,
        OWN_DM
    } owner_t;

    typedef struct packed {
        logic                  write;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
        logic [ARB_STRB_W-1:0] wstrb;
    } req_t;

endpackage

// File: rtl/mem_arb_timeout.sv
// Response-wait counter for the memory port arbiter.
// Saturates at its limit; expire marks the last allowed wait cycle.
module mem_arb_timeout #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW =
        (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CW-1:0] LIMIT =
        (TIMEOUT_CYC > 0) ? CW'(TIMEOUT_CYC - 1) : '0;

    logic [CW-1:0] cnt_q;

    // count wait cycles, cleared when a request is accepted
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != LIMIT)) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign expire = (TIMEOUT_CYC > 0) ? (cnt_q == LIMIT) : 1'b0;

endmodule

// File: rtl/mem_port_arb.sv
// Shares one bus port between instruction fetch and MEM-stage data.
// One outstanding transaction; DM has fixed priority over IM.
module mem_port_arb
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = ARB_ADDR_W,
    parameter int DATA_W      = ARB_DATA_W,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_im_req,
    input  logic [ADDR_W-1:0]   i_im_addr,
    output logic [DATA_W-1:0]   o_im_rdata,
    output logic                o_im_err,
    output logic                o_im_stall,
    input  logic                i_dm_req,
    input  logic [DATA_W/8-1:0] i_dm_web,
    input  logic [ADDR_W-1:0]   i_dm_addr,
    input  logic [DATA_W-1:0]   i_dm_wdata,
    output logic [DATA_W-1:0]   o_dm_rdata,
    output logic                o_dm_err,
    output logic                o_mem_stall,
    output logic                o_bus_valid,
    input  logic                i_bus_ready,
    output logic                o_bus_write,
    output logic [ADDR_W-1:0]   o_bus_addr,
    output logic [DATA_W-1:0]   o_bus_wdata,
    output logic [DATA_W/8-1:0] o_bus_wstrb,
    input  logic                i_bus_resp,
    input  logic [DATA_W-1:0]   i_bus_rdata,
    input  logic                i_bus_err
);

    state_t state_q, state_d;
    owner_t owner_q, owner_d;
    req_t   req_q, req_d;
    logic   valid_q;

    logic [DATA_W-1:0] im_rdata_q, dm_rdata_q;
    logic              im_err_q, dm_err_q;

    logic              cnt_clr, cnt_en, cnt_exp;
    logic              cap;
    logic [DATA_W-1:0] cap_rdata;
    logic              cap_err;

    mem_arb_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .expire (cnt_exp)
    );

    // next-state, request latch and response capture decisions
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        req_d     = req_q;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        cap       = 1'b0;
        cap_rdata = '0;
        cap_err   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_dm_req) begin
                    state_d     = REQ;
                    owner_d     = OWN_DM;
                    req_d.write = |i_dm_web;
                    req_d.addr  = ARB_ADDR_W'(i_dm_addr);
                    req_d.wdata = ARB_DATA_W'(i_dm_wdata);
                    req_d.wstrb = ARB_STRB_W'(i_dm_web);
                end else if (i_im_req) begin
                    state_d     = REQ;
                    owner_d     = OWN_IM;
                    req_d.write = 1'b0;
                    req_d.addr  = ARB_ADDR_W'(i_im_addr);
                    req_d.wdata = '0;
                    req_d.wstrb = '0;
                end
            end
            REQ: begin
                if (i_bus_ready) begin
                    state_d = RESP;
                    cnt_clr = 1'b1;
                end
            end
            RESP: begin
                if (i_bus_resp) begin
                    cap       = 1'b1;
                    cap_rdata = req_q.write ? '0 : i_bus_rdata;
                    cap_err   = i_bus_err;
                    state_d   = DONE;
                end else if (cnt_exp) begin
                    cap     = 1'b1;
                    cap_err = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, owner, request latch and registered bus valid
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= OWN_IM;
            req_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            req_q   <= req_d;
            valid_q <= (state_d == REQ);
        end
    end

    // per-owner result registers, held until the owner's next completion
    always_ff @(posedge clk) begin
        if (rst) begin
            im_rdata_q <= '0;
            im_err_q   <= 1'b0;
            dm_rdata_q <= '0;
            dm_err_q   <= 1'b0;
        end else if (cap) begin
            if (owner_q == OWN_DM) begin
                dm_rdata_q <= cap_rdata;
                dm_err_q   <= cap_err;
            end else begin
                im_rdata_q <= cap_rdata;
                im_err_q   <= cap_err;
            end
        end
    end

    assign o_bus_valid = valid_q;
    assign o_bus_write = req_q.write;
    assign o_bus_addr  = ADDR_W'(req_q.addr);
    assign o_bus_wdata = DATA_W'(req_q.wdata);
    assign o_bus_wstrb = (DATA_W/8)'(req_q.wstrb);

    assign o_im_rdata  = im_rdata_q;
    assign o_im_err    = im_err_q;
    assign o_dm_rdata  = dm_rdata_q;
    assign o_dm_err    = dm_err_q;

    assign o_mem_stall = i_dm_req &
        ~((state_q == DONE) && (owner_q == OWN_DM));
    assign o_im_stall  = i_im_req &
        ~((state_q == DONE) && (owner_q == OWN_IM));

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb with a short response timeout.
// Each step drives inputs after a clock edge and checks outputs.
module tb_mem_port_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_im_req;
    logic [31:0] i_im_addr;
    logic [31:0] o_im_rdata;
    logic        o_im_err;
    logic        o_im_stall;
    logic        i_dm_req;
    logic [3:0]  i_dm_web;
    logic [31:0] i_dm_addr;
    logic [31:0] i_dm_wdata;
    logic [31:0] o_dm_rdata;
    logic        o_dm_err;
    logic        o_mem_stall;
    logic        o_bus_valid;
    logic        i_bus_ready;
    logic        o_bus_write;
    logic [31:0] o_bus_addr;
    logic [31:0] o_bus_wdata;
    logic [3:0]  o_bus_wstrb;
    logic        i_bus_resp;
    logic [31:0] i_bus_rdata;
    logic        i_bus_err;

    int vectors = 0;
    int miscompares = 0;

    mem_port_arb #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_im_req    (i_im_req),
        .i_im_addr   (i_im_addr),
        .o_im_rdata  (o_im_rdata),
        .o_im_err    (o_im_err),
        .o_im_stall  (o_im_stall),
        .i_dm_req    (i_dm_req),
        .i_dm_web    (i_dm_web),
        .i_dm_addr   (i_dm_addr),
        .i_dm_wdata  (i_dm_wdata),
        .o_dm_rdata  (o_dm_rdata),
        .o_dm_err    (o_dm_err),
        .o_mem_stall (o_mem_stall),
        .o_bus_valid (o_bus_valid),
        .i_bus_ready (i_bus_ready),
        .o_bus_write (o_bus_write),
        .o_bus_addr  (o_bus_addr),
        .o_bus_wdata (o_bus_wdata),
        .o_bus_wstrb (o_bus_wstrb),
        .i_bus_resp  (i_bus_resp),
        .i_bus_rdata (i_bus_rdata),
        .i_bus_err   (i_bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(o_bus_valid), 32'd0);
        chk({tag, "_write"}, 32'(o_bus_write), 32'd0);
        chk({tag, "_addr"}, o_bus_addr, 32'd0);
        chk({tag, "_wdata"}, o_bus_wdata, 32'd0);
        chk({tag, "_wstrb"}, 32'(o_bus_wstrb), 32'd0);
        chk({tag, "_im_rdata"}, o_im_rdata, 32'd0);
        chk({tag, "_im_err"}, 32'(o_im_err), 32'd0);
        chk({tag, "_dm_rdata"}, o_dm_rdata, 32'd0);
        chk({tag, "_dm_err"}, 32'(o_dm_err), 32'd0);
        chk({tag, "_im_stall"}, 32'(o_im_stall), 32'd0);
        chk({tag, "_mem_stall"}, 32'(o_mem_stall), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        i_im_req = 1'b0;
        i_im_addr = '0;
        i_dm_req = 1'b0;
        i_dm_web = '0;
        i_dm_addr = '0;
        i_dm_wdata = '0;
        i_bus_ready = 1'b0;
        i_bus_resp = 1'b0;
        i_bus_rdata = '0;
        i_bus_err = 1'b0;
        tick();
        tick();
        settle();
        chk_all_zero("rst");
        rst = 1'b0;

        // 1: single IM read, immediate ready/resp
        tick();
        i_im_req = 1'b1;
        i_im_addr = 32'h0000_0010;
        settle();
        chk("t1_stall_c0", 32'(o_im_stall), 32'd1);
        chk("t1_valid_c0", 32'(o_bus_valid), 32'd0);
        tick();
        i_bus_ready = 1'b1;
        settle();
        chk("t1_valid_c1", 32'(o_bus_valid), 32'd1);
        chk("t1_addr_c1", o_bus_addr, 32'h0000_0010);
        chk("t1_write_c1", 32'(o_bus_write), 32'd0);
        chk("t1_stall_c1", 32'(o_im_stall), 32'd1);
        tick();
        i_bus_ready = 1'b0;
        i_bus_resp = 1'b1;
        i_bus_rdata = 32'h0000_0013;
        settle();
        chk("t1_valid_c2", 32'(o_bus_valid), 32'd0);
        chk("t1_stall_c2", 32'(o_im_stall), 32'd1);
        tick();
        i_bus_resp = 1'b0;
        settle();
        chk("t1_stall_done", 32'(o_im_stall), 32'd0);
        chk("t1_rdata", o_im_rdata, 32'h0000_0013);
        chk("t1_err", 32'(o_im_err), 32'd0);
        i_im_req = 1'b0;
        tick();
        settle();
        chk("t1_idle_valid", 32'(o_bus_valid), 32'd0);

        // 2: DM word write, ready delayed two cycles
        i_dm_req = 1'b1;
        i_dm_web = 4'hF;
        i_dm_addr = 32'h0001_0004;
        i_dm_wdata = 32'hDEAD_BEEF;
        settle();
        chk("t2_stall_c0", 32'(o_mem_stall), 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            if (k == 2) i_bus_ready = 1'b1;
            settle();
            chk("t2_valid", 32'(o_bus_valid), 32'd1);
            chk("t2_addr", o_bus_addr, 32'h0001_0004);
            chk("t2_wdata", o_bus_wdata, 32'hDEAD_BEEF);
            chk("t2_wstrb", 32'(o_bus_wstrb), 32'hF);
            chk("t2_write", 32'(o_bus_write), 32'd1);
            chk("t2_stall", 32'(o_mem_stall), 32'd1);
        end
        tick();
        i_bus_ready = 1'b0;
        i_bus_resp = 1'b1;
        i_bus_rdata = 32'h5555_5555;
        settle();
        chk("t2_valid_resp", 32'(o_bus_valid), 32'd0);
        chk("t2_stall_resp", 32'(o_mem_stall), 32'd1);
        tick();
        i_bus_resp = 1'b0;
        settle();
        chk("t2_stall_done", 32'(o_mem_stall), 32'd0);
        chk("t2_dm_rdata", o_dm_rdata, 32'd0);
        chk("t2_dm_err", 32'(o_dm_err), 32'd0);
        chk("t2_im_hold", o_im_rdata, 32'h0000_0013);
        i_dm_req = 1'b0;
        tick();

        // 3: simultaneous IM and DM, DM first
        i_im_req = 1'b1;
        i_im_addr = 32'h0000_0020;
        i_dm_req = 1'b1;
        i_dm_web = 4'h0;
        i_dm_addr = 32'h0000_0030;
        tick();
        i_bus_ready = 1'b1;
        settle();
        chk("t3_addr_dm", o_bus_addr, 32'h0000_0030);
        chk("t3_write_dm", 32'(o_bus_write), 32'd0);
        chk("t3_wstrb_dm", 32'(o_bus_wstrb), 32'd0);
        chk("t3_im_stall_a", 32'(o_im_stall), 32'd1);
        tick();
        i_bus_ready = 1'b0;
        i_bus_resp = 1'b1;
        i_bus_rdata = 32'hA5A5_0001;
        i_bus_err = 1'b1;
        tick();
        i_bus_resp = 1'b0;
        i_bus_err = 1'b0;
        settle();
        chk("t3_mem_stall_done", 32'(o_mem_stall), 32'd0);
        chk("t3_im_stall_b", 32'(o_im_stall), 32'd1);
        chk("t3_dm_rdata", o_dm_rdata, 32'hA5A5_0001);
        chk("t3_dm_err", 32'(o_dm_err), 32'd1);
        i_dm_req = 1'b0;
        tick();
        settle();
        chk("t3_im_stall_idle", 32'(o_im_stall), 32'd1);
        tick();
        i_bus_ready = 1'b1;
        settle();
        chk("t3_valid_im", 32'(o_bus_valid), 32'd1);
        chk("t3_addr_im", o_bus_addr, 32'h0000_0020);
        tick();
        i_bus_ready = 1'b0;
        i_bus_resp = 1'b1;
        i_bus_rdata = 32'h0000_0777;
        tick();
        i_bus_resp = 1'b0;
        settle();
        chk("t3_im_stall_done", 32'(o_im_stall), 32'd0);
        chk("t3_im_rdata", o_im_rdata, 32'h0000_0777);
        chk("t3_im_err", 32'(o_im_err), 32'd0);
        chk("t3_dm_err_hold", 32'(o_dm_err), 32'd1);
        i_im_req = 1'b0;
        tick();

        // 4: DM arrives while IM waits in RESP
        i_im_req = 1'b1;
        i_im_addr = 32'h0000_0040;
        tick();
        i_bus_ready = 1'b1;
        tick();
        i_bus_ready = 1'b0;
        i_dm_req = 1'b1;
        i_dm_web = 4'h0;
        i_dm_addr = 32'h0000_0050;
        settle();
        chk("t4_mem_stall_resp", 32'(o_mem_stall), 32'd1);
        tick();
        i_bus_resp = 1'b1;
        i_bus_rdata = 32'h0000_4444;
        settle();
        chk("t4_no_preempt", 32'(o_bus_valid), 32'd0);
        chk("t4_addr_im", o_bus_addr, 32'h0000_0040);
        tick();
        i_bus_resp = 1'b0;
        settle();
        chk("t4_im_stall_done", 32'(o_im_stall), 32'd0);
        chk("t4_im_rdata", o_im_rdata, 32'h0000_4444);
        chk("t4_mem_stall_im", 32'(o_mem_stall), 32'd1);
        i_im_req = 1'b0;
        tick();
        settle();
        chk("t4_mem_stall_idle", 32'(o_mem_stall), 32'd1);
        tick();
        i_bus_ready = 1'b1;
        settle();
        chk("t4_addr_dm", o_bus_addr, 32'h0000_0050);
        chk("t4_valid_dm", 32'(o_bus_valid), 32'd1);
        tick();
        i_bus_ready = 1'b0;
        i_bus_resp = 1'b1;
        i_bus_rdata = 32'h5555_AAAA;
        tick();
        i_bus_resp = 1'b0;
        settle();
        chk("t4_mem_stall_done", 32'(o_mem_stall), 32'd0);
        chk("t4_dm_rdata", o_dm_rdata, 32'h5555_AAAA);
        chk("t4_dm_err", 32'(o_dm_err), 32'd0);
        i_dm_req = 1'b0;
        tick();

        // 5: DM read times out after four RESP cycles
        i_dm_req = 1'b1;
        i_dm_web = 4'h0;
        i_dm_addr = 32'h0000_0060;
        tick();
        i_bus_ready = 1'b1;
        tick();
        i_bus_ready = 1'b0;
        i_bus_rdata = 32'h1234_5678;
        for (int k = 1; k < 4; k++) begin
            tick();
            settle();
            chk("t5_stall_wait", 32'(o_mem_stall), 32'd1);
        end
        tick();
        settle();
        chk("t5_stall_done", 32'(o_mem_stall), 32'd0);
        chk("t5_dm_err", 32'(o_dm_err), 32'd1);
        chk("t5_dm_rdata", o_dm_rdata, 32'd0);
        i_dm_req = 1'b0;
        tick();
        i_bus_resp = 1'b1;
        i_bus_rdata = 32'h0000_0BAD;
        tick();
        i_bus_resp = 1'b0;
        settle();
        chk("t5_late_rdata", o_dm_rdata, 32'd0);
        chk("t5_late_err", 32'(o_dm_err), 32'd1);
        chk("t5_late_valid", 32'(o_bus_valid), 32'd0);
        chk("t5_im_hold", o_im_rdata, 32'h0000_4444);

        // 6: reset while in RESP, then a clean IM read
        i_im_req = 1'b1;
        i_im_addr = 32'h0000_0070;
        tick();
        i_bus_ready = 1'b1;
        tick();
        i_bus_ready = 1'b0;
        rst = 1'b1;
        i_im_req = 1'b0;
        tick();
        rst = 1'b0;
        settle();
        chk_all_zero("t6_rst");
        i_im_req = 1'b1;
        i_im_addr = 32'h0000_0080;
        tick();
        i_bus_ready = 1'b1;
        settle();
        chk("t6_addr", o_bus_addr, 32'h0000_0080);
        chk("t6_valid", 32'(o_bus_valid), 32'd1);
        tick();
        i_bus_ready = 1'b0;
        i_bus_resp = 1'b1;
        i_bus_rdata = 32'h0000_8888;
        tick();
        i_bus_resp = 1'b0;
        settle();
        chk("t6_stall_done", 32'(o_im_stall), 32'd0);
        chk("t6_im_rdata", o_im_rdata, 32'h0000_8888);
        chk("t6_im_err", 32'(o_im_err), 32'd0);
        i_im_req = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
